cv32e40s_obi_resp_tracker: RTL and testbench
============================================

Name: cv32e40s_obi_resp_tracker

Overview:
Parametrised successor to the core's OBI integrity FIFO. Tracks per-transaction attributes (PMA integrity, store/load, and others) plus grant-parity errors from the OBI address phase. Presents them, in order, alongside the matching response phase. Uses a circular buffer of configurable depth and attribute width, and adds full/empty/occupancy status, overflow and underflow protocol detection, and an optional response watchdog. Instantiated once per OBI manager port (instruction and data).

Parameters:
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions; >=1, need not be a power of two
ATTR_W, 2, width of per-transaction attribute vector (e.g. bit0 integrity, bit1 store)
TIMEOUT_CYCLES, 256, watchdog limit in cycles; >=2; used only with the optional feature
CNT_W, $clog2(MAX_OUTSTANDING+1), derived localparam; not overridable

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
obi_req_i  in  1  OBI address-phase request
obi_gnt_i  in  1  OBI grant
obi_rvalid_i  in  1  OBI response valid
gntpar_err_i  in  1  grant parity error, this cycle
trans_attr_i  in  ATTR_W  attributes of the address-phase transaction
resp_attr_o  out  ATTR_W  attributes of the oldest outstanding transaction
resp_gntpar_err_o  out  1  grant-parity error recorded for the oldest outstanding transaction
outstanding_o  out  CNT_W  number of outstanding transactions
empty_o  out  1  outstanding_o == 0
full_o  out  1  outstanding_o == MAX_OUTSTANDING
protocol_err_o  out  1  single-cycle pulse on underflow or overflow
timeout_err_o  out  1  sticky watchdog error

Behaviour:
- Reset (rst=1 at clk edge): wptr, rptr, cnt, sticky gntpar bit, storage, and watchdog all cleared. All outputs 0 except empty_o=1. Reset mid-operation discards every outstanding entry.
- Push = obi_req_i & obi_gnt_i. Pop = obi_rvalid_i.
- Entry written on push: {gnterr = gntpar_err_i | gntpar_q, attr = trans_attr_i}.
- Sticky bit gntpar_q:
  - if req & !gnt: gntpar_q <= gntpar_q | gntpar_err_i
  - if req & gnt: gntpar_q <= 0
  - if !req: holds
- Push legal when !full, or when full & pop in the same cycle.
  - Legal push: write mem[wptr]; wptr advances.
  - Push while full without pop: entry dropped, pointers and cnt unchanged, protocol_err_o=1 that cycle.
- Pop legal when !empty; rptr advances.
  - Pop while empty: no state change, protocol_err_o=1.
  - A same-cycle push does not make an empty-state pop legal (a response needs an earlier grant). The push is still performed and cnt goes 0->1.
- cnt update:
  - +1 on legal push only
  - -1 on legal pop only
  - unchanged on both or neither
- Pointer wrap: index MAX_OUTSTANDING-1 -> 0. Must be correct for non-power-of-two depths.
- Output timing:
  - resp_attr_o and resp_gntpar_err_o are combinational from mem[rptr]; forced to 0 when empty.
  - Head is valid in the same cycle as rvalid.
  - An entry pushed in cycle N is visible at the head from cycle N+1.
  - outstanding_o, empty_o, full_o are registered-state outputs (derived from cnt).
  - protocol_err_o is combinational.
- No handshake back-pressure: the block never stalls OBI. Errors are reported only.

Optional Feature:
Macro CV32E40S_OBI_RESP_TIMEOUT_EN.
- Defined:
  - wait counter clears when empty, and on a legal pop.
  - Otherwise it increments each cycle while !empty, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, timeout_err_o goes to 1 and stays 1 until rst.
- Undefined: no counter logic; timeout_err_o tied to 0.

Test Plan:
1. MAX_OUTSTANDING=2, ATTR_W=2: push attr 2'b01 then 2'b10 on consecutive cycles -> outstanding_o=2, full_o=1. Two rvalids -> resp_attr_o 2'b01 then 2'b10, then empty_o=1 and resp_attr_o=0.
2. req held with gnt=0 for 3 cycles, gntpar_err_i=1 only in the first; gnt on the 4th -> resp_gntpar_err_o=1 at that response. The next transaction, with no parity error, shows 0.
3. rvalid with outstanding_o=0 -> protocol_err_o=1 for one cycle, outstanding_o stays 0. Full + gnt without rvalid -> protocol_err_o=1, outstanding_o stays 2, head unchanged.
4. MAX_OUTSTANDING=3: 7 pushes interleaved with pops, including simultaneous push+pop while full -> order preserved across wrap, outstanding_o=3 unchanged on the simultaneous cycle, no protocol_err_o.
5. rst asserted with 2 outstanding -> next cycle outstanding_o=0, empty_o=1. Following rvalid -> protocol_err_o=1.
6. With CV32E40S_OBI_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=4: push, no rvalid -> timeout_err_o=1 from the 4th cycle after the push and remains set after a later rvalid. Without the macro -> always 0.

Source files
------------

// File: rtl/cv32e40s_obi_resp_tracker.sv
// ---------------------------------------------------------------------------
// cv32e40s_obi_resp_tracker
//
// Per-port OBI transaction tracker. Every granted address phase stores its
// attribute vector plus a grant-parity error flag in a circular buffer. The
// oldest entry is shown alongside the matching response phase, so attributes
// come back in order. Also reports occupancy status and protocol violations.
// The block never stalls the bus; it only reports errors.
//
// Optional feature: define CV32E40S_OBI_RESP_TIMEOUT_EN to build a response
// watchdog. Without it, timeout_err_o is tied to 0.
//
// Parameters:
//   MAX_OUTSTANDING  accepted-but-unanswered transactions (>=1, any value)
//   ATTR_W           width of the per-transaction attribute vector
//   TIMEOUT_CYCLES   watchdog limit in cycles (>=2), watchdog build only
//   CNT_W            derived occupancy width (not overridable)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   obi_req_i/gnt_i     address phase; push = req & gnt
//   obi_rvalid_i        response phase; pop = rvalid
//   gntpar_err_i        grant parity error seen this cycle
//   trans_attr_i        attributes of the address-phase transaction
//   resp_attr_o         attributes of the oldest outstanding transaction
//   resp_gntpar_err_o   grant-parity error recorded for that transaction
//   outstanding_o       number of outstanding transactions
//   empty_o, full_o     occupancy status
//   protocol_err_o      one-cycle pulse on overflow or underflow
//   timeout_err_o       sticky watchdog error
// ---------------------------------------------------------------------------
module cv32e40s_obi_resp_tracker #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ATTR_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 256,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              obi_req_i,
    input  logic              obi_gnt_i,
    input  logic              obi_rvalid_i,
    input  logic              gntpar_err_i,
    input  logic [ATTR_W-1:0] trans_attr_i,
    output logic [ATTR_W-1:0] resp_attr_o,
    output logic              resp_gntpar_err_o,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              protocol_err_o,
    output logic              timeout_err_o
);

    // A depth of 1 still needs a 1-bit pointer.
    localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || ATTR_W < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("cv32e40s_obi_resp_tracker: illegal parameter value");
    end

    typedef struct packed {
        logic              gnterr;
        logic [ATTR_W-1:0] attr;
    } entry_t;

    entry_t [MAX_OUTSTANDING-1:0] mem_q;
    logic   [PTR_W-1:0]           wptr_q;
    logic   [PTR_W-1:0]           rptr_q;
    logic   [CNT_W-1:0]           cnt_q;
    logic                         gntpar_q;

    logic   push;
    logic   pop;
    logic   empty;
    logic   full;
    logic   push_ok;
    logic   pop_ok;
    entry_t wr_entry;
    entry_t head;

    // Wrap explicitly at the last index so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign push  = obi_req_i & obi_gnt_i;
    assign pop   = obi_rvalid_i;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == MAX_CNT);

    // A response needs an earlier grant, so a pop is only legal against
    // stored state; a same-cycle push never rescues an empty-state pop.
    assign pop_ok  = pop & ~empty;
    // Full is fine as long as the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    assign protocol_err_o = (pop & empty) | (push & full & ~pop);

    // Parity errors seen while the request waited for its grant are folded
    // into the entry that finally gets granted.
    assign wr_entry = '{gnterr: gntpar_err_i | gntpar_q, attr: trans_attr_i};

    // Head is read straight from storage: valid in the same cycle as rvalid.
    assign head              = empty ? '0 : mem_q[rptr_q];
    assign resp_attr_o       = head.attr;
    assign resp_gntpar_err_o = head.gnterr;

    assign outstanding_o = cnt_q;
    assign empty_o       = empty;
    assign full_o        = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            gntpar_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wr_entry;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop_ok) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            // Sticky across a stalled request; consumed by the grant.
            if (obi_req_i) begin
                gntpar_q <= obi_gnt_i ? 1'b0 : (gntpar_q | gntpar_err_i);
            end
        end
    end

`ifdef CV32E40S_OBI_RESP_TIMEOUT_EN
    localparam int unsigned       WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              timeout_q;

    // Counts cycles the head has been waiting for its response.
    always_comb begin
        wait_d = wait_q;
        if (empty || pop_ok) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_q | (wait_d == WAIT_MAX);
        end
    end

    assign timeout_err_o = timeout_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40s_obi_resp_tracker.sv
// Bench for cv32e40s_obi_resp_tracker. Two instances (depth 2 and depth 3)
// share one stimulus stream; each has its own queue-based scoreboard. A
// hand-derived vector table additionally pins the depth-2 instance.
module tb_cv32e40s_obi_resp_tracker;

`ifdef CV32E40S_OBI_RESP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0, gnt = 1'b0, rvalid = 1'b0, gpe = 1'b0;
    logic [1:0] attr = 2'b00;

    logic [1:0] attr2, out2, attr3, out3;
    logic       gerr2, empty2, full2, perr2, tmo2;
    logic       gerr3, empty3, full3, perr3, tmo3;

    always #5 clk = ~clk;

    cv32e40s_obi_resp_tracker #(.MAX_OUTSTANDING(2), .ATTR_W(2), .TIMEOUT_CYCLES(TMO)) dut2 (
        .clk(clk), .rst(rst), .obi_req_i(req), .obi_gnt_i(gnt), .obi_rvalid_i(rvalid),
        .gntpar_err_i(gpe), .trans_attr_i(attr), .resp_attr_o(attr2),
        .resp_gntpar_err_o(gerr2), .outstanding_o(out2), .empty_o(empty2), .full_o(full2),
        .protocol_err_o(perr2), .timeout_err_o(tmo2));

    cv32e40s_obi_resp_tracker #(.MAX_OUTSTANDING(3), .ATTR_W(2), .TIMEOUT_CYCLES(TMO)) dut3 (
        .clk(clk), .rst(rst), .obi_req_i(req), .obi_gnt_i(gnt), .obi_rvalid_i(rvalid),
        .gntpar_err_i(gpe), .trans_attr_i(attr), .resp_attr_o(attr3),
        .resp_gntpar_err_o(gerr3), .outstanding_o(out3), .empty_o(empty3), .full_o(full3),
        .protocol_err_o(perr3), .timeout_err_o(tmo3));

    int errs = 0;
    int checks = 0;

    // Scoreboard state: queued {gnterr, attr} entries per instance.
    bit [2:0] q2[$];
    bit [2:0] q3[$];
    bit       gp = 1'b0;
    int       wc2 = 0, wc3 = 0;
    bit       tm2 = 1'b0, tm3 = 1'b0;

    typedef struct {
        logic       r, g, v, e;
        logic [1:0] a;
        int         cnt;
        logic       perr;
        logic [2:0] head;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t vv(logic r, logic g, logic v, logic e, logic [1:0] a,
                                int cnt, logic perr, logic [2:0] head);
        vec_t t;
        t.r = r; t.g = g; t.v = v; t.e = e; t.a = a;
        t.cnt = cnt; t.perr = perr; t.head = head;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic g, input logic v, input logic e,
                         input logic [1:0] a);
        @(negedge clk);
        req = r; gnt = g; rvalid = v; gpe = e; attr = a;
        #1;
    endtask

    // Compare both instances against their scoreboards, then advance the
    // model to the state the upcoming clock edge should produce.
    task automatic settle_check();
        int       s2, s3;
        bit       psh, pop2, pop3;
        bit [2:0] ent, h2, h3;
        s2  = q2.size();
        s3  = q3.size();
        psh = req && gnt;
        ent = {gpe | gp, attr};
        h2  = (s2 != 0) ? q2[0] : 3'b000;
        h3  = (s3 != 0) ? q3[0] : 3'b000;

        chk("cnt2",   int'(out2), s2);
        chk("empty2", empty2, int'(s2 == 0));
        chk("full2",  full2,  int'(s2 == 2));
        chk("perr2",  perr2,  int'((rvalid && s2 == 0) || (psh && s2 == 2 && !rvalid)));
        chk("head2",  int'({gerr2, attr2}), int'(h2));
        chk("tmo2",   tmo2,   int'(TMO_EN && tm2));
        chk("cnt3",   int'(out3), s3);
        chk("empty3", empty3, int'(s3 == 0));
        chk("full3",  full3,  int'(s3 == 3));
        chk("perr3",  perr3,  int'((rvalid && s3 == 0) || (psh && s3 == 3 && !rvalid)));
        chk("head3",  int'({gerr3, attr3}), int'(h3));
        chk("tmo3",   tmo3,   int'(TMO_EN && tm3));

        pop2 = rvalid && s2 > 0;
        pop3 = rvalid && s3 > 0;
        if (pop2) void'(q2.pop_front());
        if (pop3) void'(q3.pop_front());
        if (psh && (s2 < 2 || pop2)) q2.push_back(ent);
        if (psh && (s3 < 3 || pop3)) q3.push_back(ent);

        if (s2 == 0 || pop2) wc2 = 0; else if (wc2 < TMO) wc2++;
        if (s3 == 0 || pop3) wc3 = 0; else if (wc3 < TMO) wc3++;
        if (wc2 == TMO) tm2 = 1'b1;
        if (wc3 == TMO) tm3 = 1'b1;

        if (req) gp = gnt ? 1'b0 : (gp | gpe);
        @(posedge clk);
    endtask

    task automatic tick(input logic r, input logic g, input logic v, input logic e,
                        input logic [1:0] a);
        drive(r, g, v, e, a);
        settle_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; gnt = 1'b0; rvalid = 1'b0; gpe = 1'b0; attr = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        q2.delete(); q3.delete();
        gp = 1'b0; wc2 = 0; wc3 = 0; tm2 = 1'b0; tm3 = 1'b0;
    endtask

    initial begin
        // Depth-2 vectors: inputs, then expected state seen before the edge.
        //             r  g  v  e  attr  cnt perr head{gerr,attr}
        tbl[0]  = vv(0, 0, 0, 0, 2'b00, 0, 0, 3'b000); // reset state
        tbl[1]  = vv(1, 1, 0, 0, 2'b01, 0, 0, 3'b000); // push 01
        tbl[2]  = vv(1, 1, 0, 0, 2'b10, 1, 0, 3'b001); // push 10
        tbl[3]  = vv(0, 0, 0, 0, 2'b00, 2, 0, 3'b001); // full
        tbl[4]  = vv(1, 1, 0, 0, 2'b11, 2, 1, 3'b001); // overflow, dropped
        tbl[5]  = vv(0, 0, 1, 0, 2'b00, 2, 0, 3'b001); // pop 01
        tbl[6]  = vv(0, 0, 1, 0, 2'b00, 1, 0, 3'b010); // pop 10
        tbl[7]  = vv(0, 0, 0, 0, 2'b00, 0, 0, 3'b000); // empty again
        tbl[8]  = vv(0, 0, 1, 0, 2'b00, 0, 1, 3'b000); // underflow
        tbl[9]  = vv(0, 0, 0, 0, 2'b00, 0, 0, 3'b000);
        tbl[10] = vv(1, 0, 0, 1, 2'b00, 0, 0, 3'b000); // stalled req, parity err
        tbl[11] = vv(1, 0, 0, 0, 2'b00, 0, 0, 3'b000);
        tbl[12] = vv(1, 0, 0, 0, 2'b00, 0, 0, 3'b000);
        tbl[13] = vv(1, 1, 0, 0, 2'b01, 0, 0, 3'b000); // granted: carries err
        tbl[14] = vv(1, 1, 0, 0, 2'b10, 1, 0, 3'b101); // clean transaction
        tbl[15] = vv(0, 0, 1, 0, 2'b00, 2, 0, 3'b101);
        tbl[16] = vv(0, 0, 1, 0, 2'b00, 1, 0, 3'b010);
        tbl[17] = vv(0, 0, 0, 1, 2'b00, 0, 0, 3'b000); // err without req ignored
        tbl[18] = vv(1, 1, 0, 0, 2'b11, 0, 0, 3'b000);
        tbl[19] = vv(1, 1, 1, 0, 2'b01, 1, 0, 3'b011); // push+pop, not full
        tbl[20] = vv(1, 1, 1, 1, 2'b10, 1, 0, 3'b001); // err on grant cycle
        tbl[21] = vv(0, 0, 1, 0, 2'b00, 1, 0, 3'b110);
        tbl[22] = vv(1, 1, 1, 0, 2'b01, 0, 1, 3'b000); // empty pop + push
        tbl[23] = vv(0, 0, 0, 0, 2'b00, 1, 0, 3'b001);
        tbl[24] = vv(1, 1, 0, 0, 2'b10, 1, 0, 3'b001);
        tbl[25] = vv(1, 1, 1, 0, 2'b11, 2, 0, 3'b001); // push+pop while full
        tbl[26] = vv(0, 0, 1, 0, 2'b00, 2, 0, 3'b010);
        tbl[27] = vv(0, 0, 1, 0, 2'b00, 1, 0, 3'b011);
        tbl[28] = vv(0, 0, 0, 0, 2'b00, 0, 0, 3'b000);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].r, tbl[i].g, tbl[i].v, tbl[i].e, tbl[i].a);
            chk($sformatf("tbl%0d_cnt", i),  int'(out2), tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), full2, int'(tbl[i].cnt == 2));
            chk($sformatf("tbl%0d_perr", i), perr2, int'(tbl[i].perr));
            chk($sformatf("tbl%0d_head", i), int'({gerr2, attr2}), int'(tbl[i].head));
            settle_check();
        end

        // Depth 3: seven pushes across wrap with push+pop while full.
        tick(1, 1, 0, 0, 2'b01);
        tick(1, 1, 0, 1, 2'b10);
        tick(1, 1, 0, 0, 2'b11);
        drive(1, 1, 1, 0, 2'b00);
        chk("wrap_full3", full3, 1);
        chk("wrap_perr3", perr3, 0);
        settle_check();
        drive(0, 0, 1, 0, 2'b00);
        chk("wrap_cnt3", int'(out3), 3);
        settle_check();
        tick(1, 1, 0, 0, 2'b01);
        tick(1, 1, 1, 1, 2'b10);
        tick(0, 0, 1, 0, 2'b00);
        tick(1, 1, 0, 0, 2'b11);
        repeat (4) tick(0, 0, 1, 0, 2'b00);

        // Reset with entries outstanding discards them.
        tick(1, 1, 0, 0, 2'b10);
        tick(1, 1, 0, 0, 2'b01);
        do_reset();
        drive(0, 0, 0, 0, 2'b00);
        chk("rst_empty2", empty2, 1);
        chk("rst_cnt2", int'(out2), 0);
        settle_check();
        drive(0, 0, 1, 0, 2'b00);
        chk("rst_underflow2", perr2, 1);
        settle_check();

        // Watchdog: one entry left unanswered.
        tick(1, 1, 0, 0, 2'b01);
        repeat (6) tick(0, 0, 0, 0, 2'b00);
        drive(0, 0, 1, 0, 2'b00);
        chk("tmo_set2", tmo2, int'(TMO_EN));
        settle_check();
        repeat (2) tick(0, 0, 0, 0, 2'b00);
        drive(0, 0, 0, 0, 2'b00);
        chk("tmo_sticky2", tmo2, int'(TMO_EN));
        settle_check();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
